// File: rtl/adder_pipelined.sv
// Carry-chunked pipelined adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk per stage, carry registered between stages, valid/ready on both sides.

module adder_pipelined_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_c,
  output logic [CHUNK-1:0] o_s,
  output logic             o_c
);
  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_c};
endmodule

module adder_pipelined #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipelined: WIDTH must be a positive multiple of STAGES");
  end

  // Index k of w_*_in is what stage k consumes; r_* is what stage k registers.
  logic [STAGES-1:0][WIDTH-1:0] w_a_in, w_b_in, w_s_in, w_s_out;
  logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_s;
  logic [STAGES-1:0]            w_c_in, w_c_out, w_v_in;
  logic [STAGES-1:0]            r_c, r_vld_pipe;
  logic                         r_ovf, w_ovf, w_en, w_unused;

  assign w_en    = ~r_vld_pipe[L] | ready_i;
  assign ready_o = w_en;

  assign w_a_in[0] = a_i;
  assign w_b_in[0] = sub_i ? ~b_i : b_i;
  assign w_s_in[0] = '0;
  assign w_c_in[0] = sub_i ^ cin_i;
  assign w_v_in[0] = valid_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);
    logic [CHUNK-1:0] w_chunk;

    if (k > 0) begin : g_link
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_v_in[k] = r_vld_pipe[k-1];
    end

    adder_pipelined_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a (w_a_in[k][k*CHUNK +: CHUNK]),
      .i_b (w_b_in[k][k*CHUNK +: CHUNK]),
      .i_c (w_c_in[k]),
      .o_s (w_chunk),
      .o_c (w_c_out[k])
    );

    assign w_s_out[k] = (w_s_in[k] & ~MASK) | (WIDTH'(w_chunk) << (k * CHUNK));
  end

  // Carry into the MSB is recovered from the MSB sum bit: c_in = a ^ b ^ s.
  assign w_ovf = w_a_in[L][WIDTH-1] ^ w_b_in[L][WIDTH-1] ^ w_s_out[L][WIDTH-1] ^ w_c_out[L];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_a        <= '0;
      r_b        <= '0;
      r_s        <= '0;
      r_c        <= '0;
      r_vld_pipe <= '0;
      r_ovf      <= 1'b0;
    end else if (w_en) begin
      r_a        <= w_a_in;
      r_b        <= w_b_in;
      r_s        <= w_s_out;
      r_c        <= w_c_out;
      r_vld_pipe <= w_v_in;
      r_ovf      <= w_ovf;
    end
  end

  // Operand copies leaving the last stage have no consumer.
  assign w_unused = ^{r_a[L], r_b[L]};

  assign sum_o   = r_s[L];
  assign cout_o  = r_c[L];
  assign ovf_o   = r_ovf;
  assign valid_o = r_vld_pipe[L];
endmodule

// File: tb/tb_adder_pipelined.sv
// Directed-vector bench for adder_pipelined (WIDTH=8, STAGES=4): single ops,
// latency, async/mid-stream reset, back-to-back stream with stall, random flow.
module tb_adder_pipelined;
  localparam int W = 8;
  localparam int S = 4;

  logic         clk_i = 1'b0;
  logic         reset_n_i, valid_i, ready_o, cin_i, sub_i, cout_o, ovf_o, valid_o, ready_i;
  logic [W-1:0] a_i, b_i, sum_o;

  int checks = 0;
  int errors = 0;

  adder_pipelined #(.WIDTH(W), .STAGES(S)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i), .sum_o(sum_o),
    .cout_o(cout_o), .ovf_o(ovf_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co, ov;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic res_t golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
    res_t r;
    int t, st, sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      t  = int'(a) + int'(b) + int'(cin);
      st = sa + sb + int'(cin);
      r.co = (t > 255);
    end else begin
      t  = int'(a) - int'(b) - int'(cin);
      st = sa - sb - int'(cin);
      r.co = (t >= 0);
    end
    r.s  = t[W-1:0];
    r.ov = (st > 127) || (st < -128);
    return r;
  endfunction

  task automatic run_one(input vec_t v, input int idx);
    int  lat;
    bit  found;
    @(negedge clk_i);
    a_i = v.a; b_i = v.b; cin_i = v.cin; sub_i = v.sub; valid_i = 1'b1;
    #1 chk($sformatf("v%0d_ready", idx), 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    lat = 0; found = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk_i);
      if (valid_o) begin found = 1; break; end
      @(posedge clk_i);
      lat++;
    end
    chk($sformatf("v%0d_found", idx), 32'(found), 32'd1);
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(S - 1));
    chk($sformatf("v%0d_sum", idx), 32'(sum_o), 32'(v.s));
    chk($sformatf("v%0d_cout", idx), 32'(cout_o), 32'(v.co));
    chk($sformatf("v%0d_ovf", idx), 32'(ovf_o), 32'(v.ov));
    @(posedge clk_i);
    @(negedge clk_i);
    chk($sformatf("v%0d_nodup", idx), 32'(valid_o), 32'd0);
  endtask

  // mode 0: fixed 3-cycle stall mid-stream; mode 1: random valid/ready.
  task automatic run_stream(input int n, input int mode, input string tag);
    res_t   q[$];
    res_t   e, exp_r;
    int     idx, got, cyc;
    bit     stalled;
    logic [W-1:0] hs;
    logic         hc, ho;
    logic [W-1:0] sa, sb;
    logic         scin, ssub;
    idx = 0; got = 0; cyc = 0; stalled = 0;
    hs = '0; hc = 0; ho = 0;
    sa = '0; sb = '0; scin = 0; ssub = 0;
    while (got < n && cyc < 20 * n + 50) begin
      @(negedge clk_i);
      cyc++;
      if (stalled) begin
        chk({tag, "_hold_vld"}, 32'(valid_o), 32'd1);
        chk({tag, "_hold_sum"}, 32'(sum_o), 32'(hs));
        chk({tag, "_hold_co"}, 32'(cout_o), 32'(hc));
        chk({tag, "_hold_ov"}, 32'(ovf_o), 32'(ho));
      end
      if (mode == 0) ready_i = !(cyc >= 8 && cyc < 11);
      else           ready_i = ($urandom_range(0, 3) != 0);
      if (!valid_i && idx < n && (mode == 0 || $urandom_range(0, 2) != 0)) begin
        sa = W'(idx * 37 + 5 + (mode * $urandom_range(0, 255)));
        sb = W'(idx * 91 + 3 + (mode * $urandom_range(0, 255)));
        scin = 1'(idx >> 1);
        ssub = 1'(idx);
        if (mode == 1) begin scin = 1'($urandom); ssub = 1'($urandom); end
      end
      valid_i = (idx < n) && (mode == 0 || valid_i || $urandom_range(0, 2) != 0);
      a_i = sa; b_i = sb; cin_i = scin; sub_i = ssub;
      #1;
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          chk({tag, "_spurious"}, 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("%s_sum%0d", tag, got), 32'(sum_o), 32'(e.s));
          chk($sformatf("%s_co%0d", tag, got), 32'(cout_o), 32'(e.co));
          chk($sformatf("%s_ov%0d", tag, got), 32'(ovf_o), 32'(e.ov));
        end
        got++;
      end
      stalled = valid_o && !ready_i;
      if (stalled) begin
        chk({tag, "_stall_rdy"}, 32'(ready_o), 32'd0);
        hs = sum_o; hc = cout_o; ho = ovf_o;
      end
      if (valid_i && ready_o) begin
        exp_r = golden(sa, sb, scin, ssub);
        q.push_back(exp_r);
        idx++;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk({tag, "_issued"}, 32'(idx), 32'(n));
    chk({tag, "_received"}, 32'(got), 32'(n));
    chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   stale;
    tbl[0]  = '{8'hFF, 8'h01, 0, 0, 8'h00, 1, 0};
    tbl[1]  = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
    tbl[2]  = '{8'h80, 8'hFF, 0, 0, 8'h7F, 1, 1};
    tbl[3]  = '{8'h05, 8'h07, 0, 1, 8'hFE, 0, 0};
    tbl[4]  = '{8'h07, 8'h05, 1, 1, 8'h01, 1, 0};
    tbl[5]  = '{8'h00, 8'h00, 1, 0, 8'h01, 0, 0};
    tbl[6]  = '{8'h0F, 8'h01, 0, 0, 8'h10, 0, 0};
    tbl[7]  = '{8'h80, 8'h01, 0, 1, 8'h7F, 1, 1};
    tbl[8]  = '{8'hFF, 8'hFF, 1, 0, 8'hFF, 1, 0};
    tbl[9]  = '{8'h00, 8'h00, 0, 1, 8'h00, 1, 0};
    tbl[10] = '{8'h00, 8'h00, 1, 1, 8'hFF, 0, 0};
    tbl[11] = '{8'h40, 8'h40, 0, 0, 8'h80, 0, 1};

    reset_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_sum", 32'(sum_o), 32'd0);
    chk("rst_cout", 32'(cout_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    reset_n_i = 1'b1;
    ready_i = 1'b1;

    for (int i = 0; i < 12; i++) run_one(tbl[i], i);

    // Async reset while a result sits stalled at the output.
    ready_i = 1'b0;
    @(negedge clk_i);
    a_i = 8'h12; b_i = 8'h34; cin_i = 0; sub_i = 0; valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    for (int t = 0; t < 10 && !valid_o; t++) @(negedge clk_i);
    chk("ar_pre_valid", 32'(valid_o), 32'd1);
    chk("ar_pre_sum", 32'(sum_o), 32'h46);
    @(posedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_o), 32'd0);
    chk("ar_sum", 32'(sum_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    ready_i = 1'b1;
    stale = 0;
    repeat (8) begin @(negedge clk_i); if (valid_o) stale++; end
    chk("ar_no_stale", 32'(stale), 32'd0);

    // Reset with three ops in flight.
    @(negedge clk_i);
    valid_i = 1'b1; a_i = 8'h01; b_i = 8'h02;
    repeat (3) @(negedge clk_i);
    valid_i = 1'b0;
    reset_n_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    stale = 0;
    repeat (8) begin @(negedge clk_i); if (valid_o) stale++; end
    chk("mr_no_stale", 32'(stale), 32'd0);

    run_stream(16, 0, "stall");
    run_stream(300, 1, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
